jtag_chain_protocol_monitor: RTL and testbench
==============================================

JTAG_CHAIN_PROTOCOL_MONITOR -- requirements
Module: jtag_chain_protocol_monitor

Interface
REQ-001 SHALL have parameter NCHAIN, default 4: number of monitored chains, legal range 1..32.
REQ-002 SHALL have parameter CNT_W, default 8: error-counter width, legal range 2..16.
REQ-003 SHALL have port clock, input, 1 bit: sole clock, all state updates on its rising edge.
REQ-004 SHALL have port reset, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have port enable, input, 1 bit: checking enabled when high.
REQ-006 SHALL have port clear, input, 1 bit: synchronous clear of error state.
REQ-007 SHALL have port capture, input, NCHAIN bits: per-chain capture strobe.
REQ-008 SHALL have port shift, input, NCHAIN bits: per-chain shift strobe.
REQ-009 SHALL have port update, input, NCHAIN bits: per-chain update strobe.
REQ-010 SHALL have port err_excl, output, NCHAIN bits: sticky per-chain mutual-exclusion error.
REQ-011 SHALL have port err_seq, output, NCHAIN bits: sticky per-chain sequence error.
REQ-012 SHALL have port err_count, output, CNT_W bits: saturating total error-event count.
REQ-013 SHALL have port first_valid, output, 1 bit: first-error record is valid.
REQ-014 SHALL have port first_chan, output, clog2(NCHAIN) bits (min 1): chain index of first error.
REQ-015 SHALL have port first_code, output, 2 bits: 01 = exclusion, 10 = sequence.

Function
- REQ-016 Exclusion violation on chain i SHALL be flagged when at least two of capture[i], shift[i], update[i] are high in the same cycle.
- REQ-017 Each chain SHALL run its own FSM with states IDLE, CAPTURED, SHIFTING.
- REQ-018 FSM transitions SHALL be:
  - capture in any state -> CAPTURED;
  - shift in CAPTURED or SHIFTING -> SHIFTING;
  - update in CAPTURED or SHIFTING -> IDLE;
  - no strobe -> hold.
- REQ-019 Sequence violation SHALL be flagged for shift or update seen in IDLE; the FSM SHALL stay in IDLE.
- REQ-020 On an exclusion violation the FSM SHALL go to IDLE, and no sequence check SHALL be made for that chain that cycle.
- REQ-021 Every flag, counter and first-error output SHALL reflect a violation one clock after the violating input cycle.
- REQ-022 err_count SHALL add the number of violation events in the cycle (exclusion plus sequence, summed over all chains) and SHALL saturate at 2^CNT_W-1.
- REQ-023 The first-error record SHALL latch only while first_valid is 0; when several chains fail in one cycle the lowest index SHALL win, and exclusion SHALL win over sequence.
- REQ-024 When clear is high: err_excl, err_seq, err_count and first_valid SHALL be zeroed; FSM states SHALL NOT be affected.
- REQ-025 When clear coincides with a new violation, the new violation SHALL win: flags set, err_count = that cycle's event count, first record latched.
- REQ-026 While enable is low: FSMs SHALL hold, no violations SHALL be flagged, and clear SHALL still act.

Reset
- REQ-027 Asserting reset SHALL immediately force all FSMs to IDLE and all outputs to 0 (err_excl, err_seq, err_count, first_valid, first_chan, first_code).
- REQ-028 A reset asserted mid-sequence SHALL discard chain progress, so an update directly after deassertion is a sequence error.

Configuration
- REQ-029 With macro JTAG_MON_ASSERT_EN defined, a simulation-only immediate assertion SHALL fire, with a message naming the chain and violation type, on each violation while reset is deasserted and enable is high.
- REQ-030 Without JTAG_MON_ASSERT_EN, no assertion or message logic SHALL exist; flag behaviour SHALL be identical.

Verification
- REQ-031 NCHAIN=4: capture[2]=shift[2]=1 for one cycle -> next cycle err_excl=0100, err_count=1, first_chan=2, first_code=01.
- REQ-032 update[0] after reset with no prior capture -> err_seq=0001, first_code=10; then capture, shift x3, update on chain 0 -> no further errors.
- REQ-033 One cycle with update on chains 1 and 3 in IDLE plus a capture/update overlap on chain 3 -> err_seq=0010, err_excl=1000, err_count=2, first_chan=1, first_code=10.
- REQ-034 CNT_W=2: five single violations -> err_count=3 held; clear together with one new violation -> err_count=1.
- REQ-035 Chain 0 in SHIFTING; assert reset for 1 cycle, then update[0] -> err_seq[0]=1.
- REQ-036 enable=0 with illegal strobes -> all outputs stay 0; FSM holds through the window.

Source files
------------

// File: rtl/jtag_chain_protocol_monitor.sv
// JTAG chain protocol monitor: per-chain capture/shift/update sequencing and
// strobe exclusion checks. Optional macro JTAG_MON_ASSERT_EN adds sim asserts.
module jtag_chain_protocol_monitor #(
    parameter int NCHAIN = 4,
    parameter int CNT_W  = 8
) (
    input  logic                                     clock,
    input  logic                                     reset,
    input  logic                                     enable,
    input  logic                                     clear,
    input  logic [NCHAIN-1:0]                        capture,
    input  logic [NCHAIN-1:0]                        shift,
    input  logic [NCHAIN-1:0]                        update,
    output logic [NCHAIN-1:0]                        err_excl,
    output logic [NCHAIN-1:0]                        err_seq,
    output logic [CNT_W-1:0]                         err_count,
    output logic                                     first_valid,
    output logic [((NCHAIN>1)?$clog2(NCHAIN):1)-1:0] first_chan,
    output logic [1:0]                               first_code
);

    localparam int CW = (NCHAIN > 1) ? $clog2(NCHAIN) : 1;
    // Headroom for up to 2*32 events per cycle on top of the counter.
    localparam int AW = CNT_W + 7;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        CAPTURED = 2'd1,
        SHIFTING = 2'd2
    } state_t;

    state_t            state_q [NCHAIN];
    logic [NCHAIN-1:0] excl;
    logic [NCHAIN-1:0] seq;

    logic [NCHAIN-1:0] err_excl_q, err_excl_d;
    logic [NCHAIN-1:0] err_seq_q, err_seq_d;
    logic [CNT_W-1:0]  err_count_q, err_count_d;
    logic              first_valid_q;
    logic [CW-1:0]     first_chan_q;
    logic [1:0]        first_code_q;

    logic [AW-1:0]     sum;
    logic              hit;
    logic [CW-1:0]     hit_idx;
    logic [1:0]        hit_code;

    // Per-chain violation detection; an exclusion hit suppresses the sequence check.
    always_comb begin
        excl = '0;
        seq  = '0;
        for (int i = 0; i < NCHAIN; i++) begin
            if (enable) begin
                excl[i] = (capture[i] & shift[i])
                        | (capture[i] & update[i])
                        | (shift[i] & update[i]);
                seq[i]  = !excl[i] && (state_q[i] == IDLE)
                        && (shift[i] | update[i]);
            end
        end
    end

    // Per-chain protocol FSMs; frozen while checking is disabled.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NCHAIN; i++) state_q[i] <= IDLE;
        end else if (enable) begin
            for (int i = 0; i < NCHAIN; i++) begin
                if (excl[i])
                    state_q[i] <= IDLE;
                else if (capture[i])
                    state_q[i] <= CAPTURED;
                else if (shift[i] && state_q[i] != IDLE)
                    state_q[i] <= SHIFTING;
                else if (update[i])
                    state_q[i] <= IDLE;
            end
        end
    end

    // Sticky flags and saturating event count; clear drops history, not new events.
    always_comb begin
        err_excl_d = (clear ? '0 : err_excl_q) | excl;
        err_seq_d  = (clear ? '0 : err_seq_q) | seq;
        sum = clear ? '0 : {7'd0, err_count_q};
        for (int i = 0; i < NCHAIN; i++) begin
            sum = sum + AW'(excl[i]) + AW'(seq[i]);
        end
        if (sum > {7'd0, {CNT_W{1'b1}}})
            err_count_d = '1;
        else
            err_count_d = sum[CNT_W-1:0];
    end

    // Lowest-index failing chain; a chain can only carry one violation type per cycle.
    always_comb begin
        hit      = 1'b0;
        hit_idx  = '0;
        hit_code = 2'b00;
        for (int i = NCHAIN - 1; i >= 0; i--) begin
            if (excl[i] | seq[i]) begin
                hit      = 1'b1;
                hit_idx  = CW'(i);
                hit_code = excl[i] ? 2'b01 : 2'b10;
            end
        end
    end

    // Error state registers; first-error record latches once until cleared.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            err_excl_q    <= '0;
            err_seq_q     <= '0;
            err_count_q   <= '0;
            first_valid_q <= 1'b0;
            first_chan_q  <= '0;
            first_code_q  <= 2'b00;
        end else begin
            err_excl_q  <= err_excl_d;
            err_seq_q   <= err_seq_d;
            err_count_q <= err_count_d;
            if ((!first_valid_q || clear) && hit) begin
                first_valid_q <= 1'b1;
                first_chan_q  <= hit_idx;
                first_code_q  <= hit_code;
            end else if (clear) begin
                first_valid_q <= 1'b0;
            end
        end
    end

    assign err_excl    = err_excl_q;
    assign err_seq     = err_seq_q;
    assign err_count   = err_count_q;
    assign first_valid = first_valid_q;
    assign first_chan  = first_chan_q;
    assign first_code  = first_code_q;

`ifdef JTAG_MON_ASSERT_EN
    // Simulation-only report of every violation seen while active.
    always @(posedge clock) begin
        if (reset && enable) begin
            for (int i = 0; i < NCHAIN; i++) begin
                assert (!excl[i])
                else $error("jtag_mon: chain %0d exclusion violation", i);
                assert (!seq[i])
                else $error("jtag_mon: chain %0d sequence violation", i);
            end
        end
    end
`endif

endmodule

// File: tb/tb_jtag_chain_protocol_monitor.sv
// Randomised bench for jtag_chain_protocol_monitor against a behavioural model.
// Two instances share stimulus: default counter and a 2-bit saturating counter.
module tb_jtag_chain_protocol_monitor;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic       enable = 1'b0;
    logic       clear = 1'b0;
    logic [3:0] capture = '0;
    logic [3:0] shift = '0;
    logic [3:0] update = '0;

    logic [3:0] err_excl, err_seq;
    logic [7:0] err_count;
    logic       first_valid;
    logic [1:0] first_chan;
    logic [1:0] first_code;

    logic [3:0] err_excl2, err_seq2;
    logic [1:0] err_count2;
    logic       first_valid2;
    logic [1:0] first_chan2;
    logic [1:0] first_code2;

    int errors = 0;
    int checks = 0;

    // model: 0 = idle, 1 = captured, 2 = shifting
    int       mst [4];
    bit [3:0] mexcl, mseq;
    int       mcnt8, mcnt2;
    bit       mfv;
    int       mchan, mcode;

    always #5 clock = ~clock;

    jtag_chain_protocol_monitor #(.NCHAIN(4), .CNT_W(8)) dut (
        .clock(clock), .reset(reset), .enable(enable), .clear(clear),
        .capture(capture), .shift(shift), .update(update),
        .err_excl(err_excl), .err_seq(err_seq), .err_count(err_count),
        .first_valid(first_valid), .first_chan(first_chan),
        .first_code(first_code)
    );

    jtag_chain_protocol_monitor #(.NCHAIN(4), .CNT_W(2)) dut2 (
        .clock(clock), .reset(reset), .enable(enable), .clear(clear),
        .capture(capture), .shift(shift), .update(update),
        .err_excl(err_excl2), .err_seq(err_seq2), .err_count(err_count2),
        .first_valid(first_valid2), .first_chan(first_chan2),
        .first_code(first_code2)
    );

    task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 4; i++) mst[i] = 0;
        mexcl = '0; mseq = '0; mcnt8 = 0; mcnt2 = 0;
        mfv = 0; mchan = 0; mcode = 0;
    endtask

    task automatic model_step(bit en, bit clr, bit [3:0] c, bit [3:0] s, bit [3:0] u);
        bit [3:0] ex, sq;
        int ev;
        ex = '0; sq = '0; ev = 0;
        if (en) begin
            for (int i = 0; i < 4; i++) begin
                int n;
                n = int'(c[i]) + int'(s[i]) + int'(u[i]);
                if (n >= 2) begin
                    ex[i] = 1; mst[i] = 0;
                end else if (c[i]) begin
                    mst[i] = 1;
                end else if (s[i] || u[i]) begin
                    if (mst[i] == 0) sq[i] = 1;
                    else mst[i] = s[i] ? 2 : 0;
                end
            end
        end
        for (int i = 0; i < 4; i++) ev += int'(ex[i]) + int'(sq[i]);
        if (clr) begin
            mexcl = '0; mseq = '0; mcnt8 = 0; mcnt2 = 0; mfv = 0;
        end
        mexcl |= ex;
        mseq  |= sq;
        mcnt8 = (mcnt8 + ev > 255) ? 255 : mcnt8 + ev;
        mcnt2 = (mcnt2 + ev > 3) ? 3 : mcnt2 + ev;
        if (!mfv && ev > 0) begin
            for (int i = 3; i >= 0; i--) begin
                if (ex[i] || sq[i]) begin
                    mchan = i;
                    mcode = ex[i] ? 1 : 2;
                end
            end
            mfv = 1;
        end
    endtask

    task automatic compare_all();
        chk("err_excl", err_excl, mexcl);
        chk("err_seq", err_seq, mseq);
        chk("err_count", err_count, mcnt8);
        chk("first_valid", first_valid, mfv);
        chk("first_chan", first_chan, mchan);
        chk("first_code", first_code, mcode);
        chk("err_count2", err_count2, mcnt2);
        chk("err_seq2", err_seq2, mseq);
    endtask

    task automatic step(bit en, bit clr, bit [3:0] c, bit [3:0] s, bit [3:0] u);
        @(negedge clock);
        enable = en; clear = clr; capture = c; shift = s; update = u;
        model_step(en, clr, c, s, u);
        @(posedge clock);
        #1;
        compare_all();
    endtask

    task automatic do_reset();
        @(negedge clock);
        enable = 0; clear = 0; capture = '0; shift = '0; update = '0;
        reset = 0;
        #1;
        model_reset();
        chk("rst_excl", err_excl, 0);
        chk("rst_count", err_count, 0);
        chk("rst_first", {first_valid, first_chan, first_code}, 0);
        @(negedge clock);
        reset = 1;
    endtask

    initial begin
        model_reset();
        #1;
        chk("por_excl", err_excl, 0);
        chk("por_seq", err_seq, 0);
        chk("por_count", err_count, 0);
        chk("por_first", {first_valid, first_chan, first_code}, 0);
        @(negedge clock);
        reset = 1;

        // capture/shift overlap on chain 2
        step(1, 0, 4'b0100, 4'b0100, 4'b0000);
        chk("x31_excl", err_excl, 4'b0100);
        chk("x31_count", err_count, 1);
        chk("x31_chan", first_chan, 2);
        chk("x31_code", first_code, 2'b01);

        // update with no capture, then a clean sequence
        do_reset();
        step(1, 0, 4'b0000, 4'b0000, 4'b0001);
        chk("x32_seq", err_seq, 4'b0001);
        chk("x32_code", first_code, 2'b10);
        step(1, 0, 4'b0001, 4'b0000, 4'b0000);
        for (int k = 0; k < 3; k++) step(1, 0, 4'b0000, 4'b0001, 4'b0000);
        step(1, 0, 4'b0000, 4'b0000, 4'b0001);
        chk("x32_count", err_count, 1);

        // mixed sequence and exclusion in one cycle
        do_reset();
        step(1, 0, 4'b1000, 4'b0000, 4'b1010);
        chk("x33_seq", err_seq, 4'b0010);
        chk("x33_excl", err_excl, 4'b1000);
        chk("x33_count", err_count, 2);
        chk("x33_chan", first_chan, 1);
        chk("x33_code", first_code, 2'b10);

        // 2-bit counter saturation, then clear with a new violation
        do_reset();
        for (int k = 0; k < 5; k++) step(1, 0, 4'b0000, 4'b0000, 4'b0001);
        chk("x34_sat", err_count2, 3);
        step(1, 1, 4'b0000, 4'b0000, 4'b0100);
        chk("x34_clr", err_count2, 1);
        chk("x34_chan", first_chan, 2);

        // reset mid-sequence discards progress
        do_reset();
        step(1, 0, 4'b0001, 4'b0000, 4'b0000);
        step(1, 0, 4'b0000, 4'b0001, 4'b0000);
        do_reset();
        step(1, 0, 4'b0000, 4'b0000, 4'b0001);
        chk("x35_seq", err_seq[0], 1);

        // disabled window: nothing flagged, FSM frozen in captured
        do_reset();
        step(1, 0, 4'b0001, 4'b0000, 4'b0000);
        step(0, 0, 4'b1111, 4'b1111, 4'b0000);
        step(0, 0, 4'b0000, 4'b0000, 4'b0001);
        step(0, 0, 4'b0000, 4'b1110, 4'b1110);
        chk("x36_quiet", {err_excl, err_seq, err_count, first_valid}, 0);
        step(1, 0, 4'b0000, 4'b0001, 4'b0000);
        step(1, 0, 4'b0000, 4'b0000, 4'b0001);
        chk("x36_hold", err_count, 0);

        // randomized traffic
        do_reset();
        for (int n = 0; n < 3000; n++) begin
            bit [3:0] c, s, u;
            bit en, clr;
            c = '0; s = '0; u = '0;
            for (int i = 0; i < 4; i++) begin
                int r;
                r = $urandom_range(0, 11);
                if (r == 4) c[i] = 1;
                else if (r == 5 || r == 6) s[i] = 1;
                else if (r == 7) u[i] = 1;
                else if (r >= 10) begin
                    bit [2:0] m;
                    m = 3'($urandom);
                    c[i] = m[0]; s[i] = m[1]; u[i] = m[2];
                end
            end
            en  = ($urandom_range(0, 9) != 0);
            clr = ($urandom_range(0, 19) == 0);
            if ($urandom_range(0, 199) == 0) do_reset();
            step(en, clr, c, s, u);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
